lfsr_bist_ctrl: RTL and testbench



---
 rtl/lfsr_bist_pkg.sv | 35 +++
 rtl/lfsr.sv | 38 +++
 rtl/lfsr_bist_ctrl.sv | 157 +++++++++++++++
 tb/tb_lfsr_bist_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_bist_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_bist_pkg
// Shared definitions for the LFSR built-in self-test sequencer:
//   - state_t       : sequencer state encoding (IDLE, RESET, RUN, DONE)
//   - RES_*         : 2-bit result codes reported on lfsr_bist_ctrl.result
//   - default_taps  : feedback mask for the full-period lfsr at common widths
// ---------------------------------------------------------------------------
package lfsr_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RESET = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] RES_PASS       = 2'b00;
    localparam logic [1:0] RES_BAD_RESET  = 2'b01;
    localparam logic [1:0] RES_EARLY_ZERO = 2'b10;
    localparam logic [1:0] RES_NO_RETURN  = 2'b11;

    // Tap mask (bit i set = state[i] feeds the XOR) of a primitive trinomial.
    // Widths without an entry fall back to the top two bits, which is not
    // guaranteed maximal; such instances must pass an explicit TAPS.
    function automatic logic [31:0] default_taps(input int w);
        logic [31:0] mask;
        case (w)
            4:       mask = 32'h0000_000C;   // x^4 + x^3 + 1
            20:      mask = 32'h0009_0000;   // x^20 + x^17 + 1
            default: mask = 32'h0000_0003 << (w - 2);
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr.sv
// ---------------------------------------------------------------------------
// lfsr
// Full-period (de Bruijn) shift-register generator. Starts at 0 after reset
// and visits all 2^WIDTH states, returning to 0 after exactly 2^WIDTH
// advances. It advances once per clock while not in reset.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      asynchronous active-high reset (state -> 0)
//   value out WIDTH  registered sequence value
// ---------------------------------------------------------------------------
module lfsr
    import lfsr_bist_pkg::*;
#(
    parameter int               WIDTH = 20,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] value
);

    logic fb;

    // The extra term splices the all-zero state into the maximal-length
    // cycle: 100..0 steps to 0 instead of 0..01, and 0 steps to 0..01.
    assign fb = (^(value & TAPS)) ^ (value[WIDTH-2:0] == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= {value[WIDTH-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_bist_ctrl
// Self-test sequencer for an attached full-period lfsr. On start it holds the
// lfsr in reset for RST_CYCLES cycles, then counts advances and checks that
// 0 is present at advance 0, absent for 1..2^WIDTH-1 and back at 2^WIDTH.
// Ports:
//   clk      in  1        rising-edge clock
//   rst      in  1        asynchronous active-high reset of this block
//   start    in  1        begin a test (honoured in IDLE or DONE)
//   abort    in  1        cancel a running test, back to IDLE
//   lfsr_out in  WIDTH    registered output of the attached lfsr
//   lfsr_rst out 1        registered reset to the attached lfsr
//   busy     out 1        high in RESET and RUN
//   done     out 1        high in DONE
//   result   out 2        PASS / BAD_RESET / EARLY_ZERO / NO_RETURN
//   fail_cnt out WIDTH+1  advance count of the failure, 0 on PASS
// ---------------------------------------------------------------------------
module lfsr_bist_ctrl
    import lfsr_bist_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lfsr_out,
    output logic             lfsr_rst,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result,
    output logic [WIDTH:0]   fail_cnt
);

    localparam int             RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [WIDTH:0] CNT_END  = {1'b1, {WIDTH{1'b0}}};

    state_t         state, next_state;
    logic [RCW-1:0] rst_cnt;
    logic [WIDTH:0] cnt;

    logic           start_hit;
    logic           abort_hit;
    logic           verdict_valid;
    logic [1:0]     verdict_code;
    logic [WIDTH:0] verdict_cnt;
    logic           lfsr_rst_d, busy_d, done_d;

    // abort wins over start (in IDLE) and over a same-cycle verdict (in RUN)
    assign start_hit = start && !abort && (state == ST_IDLE || state == ST_DONE);
    assign abort_hit = abort && (state == ST_RESET || state == ST_RUN);

    // ---------------- verdict on the current advance count ----------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        verdict_valid = 1'b0;
        verdict_code  = RES_PASS;
        verdict_cnt   = '0;
        if (state == ST_RUN) begin
            if (cnt == '0) begin
                if (lfsr_out != '0) begin
                    verdict_valid = 1'b1;
                    verdict_code  = RES_BAD_RESET;
                end
            end else if (cnt == CNT_END) begin
                verdict_valid = 1'b1;
                if (lfsr_out != '0) begin
                    verdict_code = RES_NO_RETURN;
                    verdict_cnt  = cnt;
                end
            end else if (lfsr_out == '0) begin
                verdict_valid = 1'b1;
                verdict_code  = RES_EARLY_ZERO;
                verdict_cnt   = cnt;
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start_hit) next_state = ST_RESET;
            ST_RESET: begin
                if (abort_hit)                next_state = ST_IDLE;
                else if (rst_cnt == RST_LAST) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (abort_hit)          next_state = ST_IDLE;
                else if (verdict_valid) next_state = ST_DONE;
            end
            ST_DONE:  if (start_hit) next_state = ST_RESET;
            default:  next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded from next_state and registered below, so the flags line up
    // with the state and no input reaches an output combinationally.
    always_comb begin
        lfsr_rst_d = (next_state == ST_RESET);
        busy_d     = (next_state == ST_RESET) || (next_state == ST_RUN);
        done_d     = (next_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_rst <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            lfsr_rst <= lfsr_rst_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // ---------------- counters ----------------
    // cnt only keeps counting while RUN continues, so it is 0 in the first
    // RUN cycle and never steps past 2^WIDTH (that value forces a verdict).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt <= '0;
            cnt     <= '0;
        end else begin
            rst_cnt <= (state == ST_RESET) ? rst_cnt + 1'b1 : '0;
            cnt     <= (state == ST_RUN && next_state == ST_RUN) ? cnt + 1'b1 : '0;
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= RES_PASS;
            fail_cnt <= '0;
        end else if (abort_hit || start_hit) begin
            result   <= RES_PASS;
            fail_cnt <= '0;
        end else if (verdict_valid) begin
            result   <= verdict_code;
            fail_cnt <= verdict_cnt;
        end
    end

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_bist_ctrl
// Self-checking bench for lfsr_bist_ctrl (WIDTH=4, RST_CYCLES=2). The PASS
// cases use the real lfsr; failure cases switch lfsr_out to a behavioural
// sequence with injected faults. Expected verdicts are queued when a test is
// started and popped when done rises.
// ---------------------------------------------------------------------------
module tb_lfsr_bist_ctrl;
    import lfsr_bist_pkg::*;

    localparam int TW   = 4;
    localparam int TRST = 2;
    localparam int FULL = 1 << TW;

    typedef struct packed {
        logic [1:0]  res;
        logic [TW:0] fc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [TW-1:0] lfsr_out;
    logic          lfsr_rst;
    logic          busy;
    logic          done;
    logic [1:0]    result;
    logic [TW:0]   fail_cnt;

    logic [TW-1:0] real_out;
    logic [TW-1:0] model_out;
    bit            use_model;
    bit            bad_reset;
    bit            no_return;
    int            early_k;
    int            model_adv;

    int            checks;
    int            errors;
    exp_t          sb_q[$];
    logic [1:0]    last_res;

    lfsr_bist_ctrl #(.WIDTH(TW), .RST_CYCLES(TRST)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .lfsr_out (lfsr_out),
        .lfsr_rst (lfsr_rst),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .fail_cnt (fail_cnt)
    );

    lfsr #(.WIDTH(TW)) u_lfsr (
        .clk   (clk),
        .rst   (lfsr_rst),
        .value (real_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural generator: counts advances since its reset and produces a
    // nonzero value except where a fault is injected or a return is due.
    always @(posedge clk) begin
        if (lfsr_rst) model_adv <= 0;
        else          model_adv <= model_adv + 1;
    end

    always_comb begin
        model_out = '0;
        if (model_adv == 0)                model_out = bad_reset ? 4'd3 : 4'd0;
        else if (model_adv == early_k)     model_out = 4'd0;
        else if ((model_adv % FULL) == 0)  model_out = no_return ? 4'd5 : 4'd0;
        else                               model_out = TW'(model_adv % FULL);
    end

    assign lfsr_out = use_model ? model_out : real_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one test from a start pulse. abort_at/restart_at are run counts
    // (cnt values) at which to act; rst_at is a cycle index after the start
    // edge at which rst is pulsed between edges. 0 disables each.
    task automatic run_test(input string tag, input logic [1:0] exp_res, input int exp_fail,
                            input int abort_at, input int rst_at, input int restart_at);
        int   n;
        int   k;
        bit   seen;
        exp_t e;
        k = (exp_res == RES_PASS) ? FULL : exp_fail;
        @(negedge clk);
        start = 1'b1;
        if (abort_at == 0 && rst_at == 0)
            sb_q.push_back('{res: exp_res, fc: TW'(0) + (TW+1)'(exp_fail)});
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        seen  = 1'b0;
        check({tag, "_busy_up"}, 32'(busy), 32'd1);
        while (!seen && n < 100) begin
            if (n <= TRST)     check({tag, "_lfsr_rst_hi"}, 32'(lfsr_rst), 32'd1);
            if (n == TRST + 1) check({tag, "_lfsr_rst_lo"}, 32'(lfsr_rst), 32'd0);
            if (abort_at != 0 && n == TRST + 1 + abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check({tag, "_abort_busy"}, 32'(busy), 32'd0);
                check({tag, "_abort_done"}, 32'(done), 32'd0);
                check({tag, "_abort_result"}, 32'(result), 32'd0);
                check({tag, "_abort_lfsr_rst"}, 32'(lfsr_rst), 32'd0);
                return;
            end
            if (rst_at != 0 && n == rst_at) begin
                check({tag, "_busy_before_rst"}, 32'(busy), 32'd1);
                #2 rst = 1'b1;
                #1;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                check({tag, "_rst_result"}, 32'(result), 32'd0);
                check({tag, "_rst_fail_cnt"}, 32'(fail_cnt), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (restart_at != 0 && n == TRST + 1 + restart_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n++;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_done_cycle"}, 32'(n), 32'(TRST + 2 + k));
            check({tag, "_busy_low"}, 32'(busy), 32'd0);
            e = sb_q.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(e.fc));
            last_res = result;
            @(negedge clk);
            check({tag, "_done_hold"}, 32'(done), 32'd1);
            check({tag, "_result_hold"}, 32'(result), 32'(e.res));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] first_res;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        use_model = 1'b0;
        bad_reset = 1'b0;
        no_return = 1'b0;
        early_k   = 0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_lfsr_rst", 32'(lfsr_rst), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_fail_cnt", 32'(fail_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Full PASS against the real lfsr
        run_test("pass", RES_PASS, 0, 0, 0, 0);

        // Injected faults via the behavioural model
        use_model = 1'b1;
        early_k   = 7;
        run_test("early", RES_EARLY_ZERO, 7, 0, 0, 0);
        early_k   = 0;
        no_return = 1'b1;
        run_test("noret", RES_NO_RETURN, 16, 0, 0, 0);
        no_return = 1'b0;
        bad_reset = 1'b1;
        run_test("badrst", RES_BAD_RESET, 0, 0, 0, 0);
        bad_reset = 1'b0;
        use_model = 1'b0;

        // Abort at cnt=9, then start+abort together in IDLE, then a clean PASS
        run_test("abort", RES_PASS, 0, 9, 0, 0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", 32'(busy), 32'd0);
        check("start_abort_idle_lfsr_rst", 32'(lfsr_rst), 32'd0);
        run_test("pass_after_abort", RES_PASS, 0, 0, 0, 0);

        // rst mid-RUN, then a test with an ignored start in RUN, then a
        // second test from DONE that must match the first
        run_test("midrst", RES_PASS, 0, 0, 8, 0);
        run_test("restart_ignored", RES_PASS, 0, 0, 0, 5);
        first_res = last_res;
        run_test("from_done", RES_PASS, 0, 0, 0, 0);
        check("repeat_result_eq", 32'(last_res), 32'(first_res));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
